// File: rtl/qa_throttle_fifo_if.sv
// Sample-stream bundle for qa_throttle_fifo: producer side drives in_*,
// the FIFO drives the throttled out_* stream plus occupancy and overflow status.
interface qa_throttle_fifo_if #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned DEPTH_LOG2 = 3
);
  logic [WIDTH-1:0]    in_data;
  logic                in_nd;
  logic [WIDTH-1:0]    out_data;
  logic                out_nd;
  logic [DEPTH_LOG2:0] count;
  logic                error;

  modport master (
    output in_data,
    output in_nd,
    input  out_data,
    input  out_nd,
    input  count,
    input  error
  );

  modport slave (
    input  in_data,
    input  in_nd,
    output out_data,
    output out_nd,
    output count,
    output error
  );
endinterface

// File: rtl/qa_throttle_fifo.sv
// In-order sample FIFO that re-emits at most one sample every SPACING cycles,
// reporting occupancy and a sticky overflow flag. No backpressure to the source.
module qa_throttle_fifo #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned DEPTH_LOG2 = 3,
  parameter int unsigned SPACING    = 1
) (
  input logic              clk,
  input logic              rst_n,
  qa_throttle_fifo_if.slave bus
);

  localparam int unsigned         Depth     = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DepthCnt  = (DEPTH_LOG2 + 1)'(Depth);
  localparam logic [7:0]          SpcReload = 8'(SPACING - 1);

  logic [WIDTH-1:0]      mem_q [Depth];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic [7:0]            spc_q, spc_d;
  logic                  error_q, error_d;
  logic                  out_nd_q, out_nd_d;
  logic [WIDTH-1:0]      out_data_q, out_data_d;
  logic                  full, rd_en, wr_en;

  always_comb begin
    full  = (count_q == DepthCnt);
    rd_en = (count_q != '0) && (spc_q == '0);
    // A pop on the same edge frees the slot, so a full FIFO can still accept.
    wr_en = bus.in_nd && (!full || rd_en);

    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    spc_d      = spc_q;
    error_d    = error_q;
    out_nd_d   = rd_en;
    out_data_d = out_data_q;

    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
    end

    if (rd_en) begin
      rd_ptr_d   = rd_ptr_q + DEPTH_LOG2'(1);
      out_data_d = mem_q[rd_ptr_q];
      spc_d      = SpcReload;
    end else if (spc_q != '0) begin
      spc_d = spc_q - 8'd1;
    end

    if (bus.in_nd && !wr_en) begin
      error_d = 1'b1;
    end

    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + (DEPTH_LOG2 + 1)'(1);
      2'b01:   count_d = count_q - (DEPTH_LOG2 + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      spc_q      <= '0;
      error_q    <= 1'b0;
      out_nd_q   <= 1'b0;
      out_data_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      spc_q      <= spc_d;
      error_q    <= error_d;
      out_nd_q   <= out_nd_d;
      out_data_q <= out_data_d;
    end
  end

  // Storage needs no reset: pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= bus.in_data;
    end
  end

  assign bus.out_data = out_data_q;
  assign bus.out_nd   = out_nd_q;
  assign bus.count    = count_q;
  assign bus.error    = error_q;

endmodule

// File: tb/tb_qa_throttle_fifo.sv
// Directed bench for qa_throttle_fifo: three instances (SPACING 1, 3, 8) with
// per-instance scoreboards of expected output samples.
module tb_qa_throttle_fifo;

  localparam int unsigned W  = 32;
  localparam int unsigned DL = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  qa_throttle_fifo_if #(.WIDTH(W), .DEPTH_LOG2(DL)) if1 ();
  qa_throttle_fifo_if #(.WIDTH(W), .DEPTH_LOG2(DL)) if3 ();
  qa_throttle_fifo_if #(.WIDTH(W), .DEPTH_LOG2(DL)) if8 ();

  qa_throttle_fifo #(.WIDTH(W), .DEPTH_LOG2(DL), .SPACING(1)) u_s1 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (if1.slave)
  );
  qa_throttle_fifo #(.WIDTH(W), .DEPTH_LOG2(DL), .SPACING(3)) u_s3 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (if3.slave)
  );
  qa_throttle_fifo #(.WIDTH(W), .DEPTH_LOG2(DL), .SPACING(8)) u_s8 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (if8.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] q1[$];
  logic [31:0] q3[$];
  logic [31:0] q8[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Any out_nd pulse must match the head of that instance's scoreboard.
  task automatic sb_pop(input int id, input logic nd, input logic [31:0] data);
    logic [31:0] exp;
    int sz;
    if (nd === 1'b0) return;
    sz = (id == 1) ? q1.size() : (id == 3) ? q3.size() : q8.size();
    if (sz == 0) begin
      check($sformatf("s%0d unexpected out_nd", id), {31'b0, nd}, 32'd0);
      return;
    end
    case (id)
      1:       exp = q1.pop_front();
      3:       exp = q3.pop_front();
      default: exp = q8.pop_front();
    endcase
    check($sformatf("s%0d out_nd level", id), {31'b0, nd}, 32'd1);
    check($sformatf("s%0d out_data", id), data, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    sb_pop(1, if1.out_nd, if1.out_data);
    sb_pop(3, if3.out_nd, if3.out_data);
    sb_pop(8, if8.out_nd, if8.out_data);
  endtask

  initial begin
    int peak;
    rst_n       = 1'b0;
    if1.in_nd   = 1'b0;
    if1.in_data = '0;
    if3.in_nd   = 1'b0;
    if3.in_data = '0;
    if8.in_nd   = 1'b0;
    if8.in_data = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst out_nd", 32'(if1.out_nd), 32'd0);
    check("rst out_data", if1.out_data, 32'd0);
    check("rst count", 32'(if1.count), 32'd0);
    check("rst error", 32'(if1.error), 32'd0);
    check("rst s8 count", 32'(if8.count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single sample, SPACING=1: two-edge latency.
    if1.in_data = 32'hA5A5_0001;
    if1.in_nd   = 1'b1;
    q1.push_back(32'hA5A5_0001);
    tick();
    check("t1 count after write", 32'(if1.count), 32'd1);
    check("t1 no bypass", 32'(if1.out_nd), 32'd0);
    if1.in_nd = 1'b0;
    tick();
    check("t1 out_nd", 32'(if1.out_nd), 32'd1);
    check("t1 count drained", 32'(if1.count), 32'd0);
    tick();
    check("t1 pulse width", 32'(if1.out_nd), 32'd0);
    check("t1 out_data hold", if1.out_data, 32'hA5A5_0001);
    check("t1 error", 32'(if1.error), 32'd0);

    // Streaming, SPACING=1: one out per cycle, occupancy stays at 1.
    for (int i = 1; i <= 6; i++) begin
      if1.in_data = 32'(i);
      if1.in_nd   = 1'b1;
      q1.push_back(32'(i));
      tick();
      check("t2 count", 32'(if1.count), 32'd1);
      check("t2 out_nd", 32'(if1.out_nd), 32'(i > 1));
    end
    if1.in_nd = 1'b0;
    tick();
    check("t2 last out_nd", 32'(if1.out_nd), 32'd1);
    check("t2 count drained", 32'(if1.count), 32'd0);
    tick();
    check("t2 scoreboard empty", 32'(q1.size()), 32'd0);
    check("t2 error", 32'(if1.error), 32'd0);

    // SPACING=3: burst of 4, pulses 3 cycles apart.
    peak = 0;
    for (int e = 0; e < 14; e++) begin
      if (e < 4) begin
        if3.in_data = 32'(10 + e);
        if3.in_nd   = 1'b1;
        q3.push_back(32'(10 + e));
      end else begin
        if3.in_nd = 1'b0;
      end
      tick();
      check("t3 out_nd timing", 32'(if3.out_nd), 32'(e == 1 || e == 4 || e == 7 || e == 10));
      if (int'(if3.count) > peak) peak = int'(if3.count);
    end
    check("t3 count peak", 32'(peak), 32'd3);
    check("t3 error", 32'(if3.error), 32'd0);
    check("t3 scoreboard empty", 32'(q3.size()), 32'd0);

    // SPACING=8: burst of 7 overflows; 6 and 7 dropped.
    for (int e = 0; e < 46; e++) begin
      if (e < 7) begin
        if8.in_data = 32'(e + 1);
        if8.in_nd   = 1'b1;
        if (e < 5) q8.push_back(32'(e + 1));
      end else begin
        if8.in_nd = 1'b0;
      end
      tick();
      if (e == 4) begin
        check("t4 count full", 32'(if8.count), 32'd4);
        check("t4 error before drop", 32'(if8.error), 32'd0);
      end
      if (e >= 5) check("t4 error sticky", 32'(if8.error), 32'd1);
      check("t4 out_nd timing", 32'(if8.out_nd),
            32'(e == 1 || (e >= 9 && e <= 33 && (e - 1) % 8 == 0)));
    end
    check("t4 count drained", 32'(if8.count), 32'd0);
    check("t4 scoreboard empty", 32'(q8.size()), 32'd0);

    // SPACING=3: full FIFO with write and pop on the same edge (edge 7).
    for (int e = 0; e < 22; e++) begin
      if (e <= 5 || e == 7) begin
        if3.in_data = (e <= 5) ? 32'(20 + e) : 32'd26;
        if3.in_nd   = 1'b1;
        q3.push_back(if3.in_data);
      end else begin
        if3.in_nd = 1'b0;
      end
      tick();
      if (e >= 5 && e <= 7) check("t5 count full", 32'(if3.count), 32'd4);
      if (e == 7) check("t5 no error on full r/w", 32'(if3.error), 32'd0);
      check("t5 out_nd timing", 32'(if3.out_nd), 32'(e % 3 == 1 && e <= 19));
    end
    check("t5 scoreboard empty", 32'(q3.size()), 32'd0);
    check("t5 error", 32'(if3.error), 32'd0);

    // Asynchronous reset mid-burst.
    for (int e = 0; e < 4; e++) begin
      if8.in_data = 32'h70 + 32'(e);
      if8.in_nd   = 1'b1;
      if1.in_data = 32'h100 + 32'(e);
      if1.in_nd   = 1'b1;
      if (e == 0) q8.push_back(32'h70);
      if (e < 3) q1.push_back(32'h100 + 32'(e));
      tick();
    end
    check("t6 s8 count pre-reset", 32'(if8.count), 32'd3);
    check("t6 s8 error pre-reset", 32'(if8.error), 32'd1);
    #2;
    if1.in_nd = 1'b0;
    if8.in_nd = 1'b0;
    rst_n     = 1'b0;
    #1;
    check("t6 s8 async count", 32'(if8.count), 32'd0);
    check("t6 s8 async error", 32'(if8.error), 32'd0);
    check("t6 s8 async out_data", if8.out_data, 32'd0);
    check("t6 s8 async out_nd", 32'(if8.out_nd), 32'd0);
    check("t6 s1 async out_nd", 32'(if1.out_nd), 32'd0);
    check("t6 s1 async out_data", if1.out_data, 32'd0);
    check("t6 s1 async count", 32'(if1.count), 32'd0);
    @(posedge clk);
    #1;
    check("t6 reset hold count", 32'(if1.count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    if1.in_data = 32'h55;
    if1.in_nd   = 1'b1;
    q1.push_back(32'h55);
    if8.in_data = 32'h55;
    if8.in_nd   = 1'b1;
    q8.push_back(32'h55);
    tick();
    check("t6 post count s1", 32'(if1.count), 32'd1);
    check("t6 post count s8", 32'(if8.count), 32'd1);
    if1.in_nd = 1'b0;
    if8.in_nd = 1'b0;
    tick();
    check("t6 post out_nd s1", 32'(if1.out_nd), 32'd1);
    check("t6 post out_nd s8", 32'(if8.out_nd), 32'd1);
    repeat (6) tick();
    check("t6 s1 scoreboard empty", 32'(q1.size()), 32'd0);
    check("t6 s8 scoreboard empty", 32'(q8.size()), 32'd0);
    check("t6 s8 error cleared", 32'(if8.error), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/qa_throttle_fifo.md
Name: qa_throttle_fifo

Overview:
Parametrised successor to the single-stream QA wrapper datapath. It accepts a (data, nd) sample stream into a FIFO of configurable depth and re-emits the samples in order, throttled to at most one output every SPACING cycles. It also reports occupancy and a sticky overflow error. It sits between a MyHDL-driven stimulus source and the DUT, or between the DUT and the bench, to model bursty producers and rate-limited consumers.

Parameters:
WIDTH, 32, sample width in bits
DEPTH_LOG2, 3, log2 of the FIFO depth; depth = 2^DEPTH_LOG2 entries; legal range 1..10
SPACING, 1, minimum cycles between successive out_nd pulses; legal range 1..255; 1 = one output per cycle

Ports:
clk  in  1  system clock; all state changes on the rising edge
rst_n  in  1  asynchronous active-low reset
in_data  in  WIDTH  input sample, valid when in_nd=1
in_nd  in  1  new-data strobe, one sample per high cycle
out_data  out  WIDTH  output sample, valid when out_nd=1
out_nd  out  1  output new-data strobe, one-cycle pulse per sample
count  out  DEPTH_LOG2+1  current FIFO occupancy, 0..2^DEPTH_LOG2
error  out  1  sticky overflow flag

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (rst_n). While rst_n=0:
  - out_data=0, out_nd=0, count=0, error=0.
  - Read/write pointers = 0; spacing counter = 0.
  - Reset takes effect immediately, not at the next edge.
  - FIFO contents are discarded. Samples in flight mid-reset are lost with no error.
- Storage: 2^DEPTH_LOG2 x WIDTH RAM, with write/read pointers of DEPTH_LOG2 bits. Pointers wrap modulo depth with no special handling.
- Write: on an edge with in_nd=1:
  - If not full, or a read occurs on the same edge, the sample is stored.
  - If full and no read occurs on that edge, the sample is dropped and error is set to 1. error stays 1 until reset.
- Read/emit: on an edge where count>0 and the spacing counter is 0:
  - The head sample is popped and registered onto out_data, with out_nd=1 for exactly the following cycle.
  - The spacing counter is loaded with SPACING-1.
- Spacing counter: on other edges it decrements if nonzero and saturates at 0.
- SPACING=1: back-to-back output every cycle while the FIFO is non-empty.
- out_data holds its last value when out_nd=0.
- Latency:
  - There is no combinational or same-edge bypass.
  - A sample written at edge k into an empty FIFO, with the spacing counter at 0, is popped at edge k+1. out_nd is then high in the cycle after edge k+1.
  - Minimum in-to-out latency is therefore 2 edges.
- count: registered occupancy, updated each edge by +1 (write only), -1 (read only), or 0 (both or neither). It never exceeds 2^DEPTH_LOG2 and never goes below 0.
- Simultaneous write and read:
  - When empty: the read is not possible, so only the write happens.
  - When full: both happen; count is unchanged; error is not set.
- Ordering: strict FIFO. Dropped samples never appear at the output.
- Backpressure: none. The source is never stalled; overflow is reported only via error.

Test Plan:
- WIDTH=32, DEPTH_LOG2=2, SPACING=1; single in_nd with in_data=0xA5A5_0001 at edge 0 -> out_nd high for one cycle after edge 1, out_data=0xA5A5_0001; count goes 1 then 0; error=0.
- Same config, in_nd held high for 6 cycles, data 1..6 -> outputs 1..6 in order, one per cycle, starting after edge 1; count never exceeds 1; error=0.
- DEPTH_LOG2=2, SPACING=3; burst of 4 samples (10,11,12,13) on consecutive edges -> out_nd pulses exactly 3 cycles apart with values 10,11,12,13; count peaks at 3; error=0.
- DEPTH_LOG2=2, SPACING=8; burst of 7 samples 1..7 -> count reaches 4; samples 6 and 7 are dropped; error=1 from the first drop onward; outputs 1,2,3,4,5 then no further out_nd; error remains 1 after the FIFO drains.
- Full FIFO (count=4) with simultaneous write and pop on the same edge -> count stays 4; error stays 0; the written sample is emitted after the existing three.
- Assert rst_n=0 asynchronously mid-burst with count=3 and error=1 -> out_nd, count, error and out_data go to 0 immediately, without waiting for a clock edge; after release, a new sample 0x55 emerges with standard 2-edge latency and no stale data appears.
